// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite ROM pixel fetcher.
package sprite_pkg;

    localparam int unsigned DEF_ADDR_W = 13;
    localparam int unsigned DEF_DATA_W = 24;
    localparam int unsigned DEF_SPR_W  = 64;
    localparam int unsigned DEF_SPR_H  = 64;
    localparam int unsigned PIX_X_W    = $clog2(DEF_SPR_W);
    localparam int unsigned PIX_Y_W    = $clog2(DEF_SPR_H);

    localparam logic [DEF_DATA_W-1:0] KEY_COLOR = 24'hFF00FF;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [PIX_X_W-1:0]    x;
        logic [PIX_Y_W-1:0]    y;
        logic                  transparent;
        logic                  last;
    } pixel_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry pixel FIFO between ROM capture and the pixel stream; head is always visible.
module pixel_skid_fifo
    import sprite_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       i_push,
    input  pixel_t     i_data,
    input  logic       i_pop,
    output pixel_t     o_head,
    output logic [1:0] o_count
);

    pixel_t     r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(i_push) - 2'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/sprite_pixel_fetcher.sv
// Walks a sprite in ROM row-major and streams its pixels with x/y tags over valid/ready.
// Optional horizontal mirror enabled by defining SPRITE_FLIPX_EN (adds flip_x input).
module sprite_pixel_fetcher #(
    parameter int unsigned       ADDR_W    = sprite_pkg::DEF_ADDR_W,
    parameter int unsigned       DATA_W    = sprite_pkg::DEF_DATA_W,
    parameter int unsigned       SPR_W     = sprite_pkg::DEF_SPR_W,
    parameter int unsigned       SPR_H     = sprite_pkg::DEF_SPR_H,
    parameter logic [DATA_W-1:0] KEY_COLOR = DATA_W'(sprite_pkg::KEY_COLOR)
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
`ifdef SPRITE_FLIPX_EN
    input  logic                     flip_x,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [DATA_W-1:0]        rom_data,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic [DATA_W-1:0]        pix_data,
    output logic [$clog2(SPR_W)-1:0] pix_x,
    output logic [$clog2(SPR_H)-1:0] pix_y,
    output logic                     pix_transparent,
    output logic                     pix_last
);
    import sprite_pkg::*;

    localparam int unsigned X_W = $clog2(SPR_W);
    localparam int unsigned Y_W = $clog2(SPR_H);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [X_W-1:0]    r_tag_x;
    logic [Y_W-1:0]    r_tag_y;
    logic              r_in_flight;

    logic              w_start_ok;
    logic              w_issue;
    logic              w_last_addr;
    logic              w_pop;
    logic [1:0]        w_occ;
    logic              w_flip;
    logic              w_flip_start;
    logic [X_W-1:0]    w_x_nxt;
    logic [Y_W-1:0]    w_y_nxt;
    logic [X_W-1:0]    w_col;
    pixel_t            w_push_pix;
    pixel_t            w_head;
    logic [1:0]        w_count;

`ifdef SPRITE_FLIPX_EN
    logic r_flip;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_flip <= 1'b0;
        end else if (w_start_ok) begin
            r_flip <= flip_x;
        end
    end

    assign w_flip       = r_flip;
    assign w_flip_start = flip_x;
`else
    assign w_flip       = 1'b0;
    assign w_flip_start = 1'b0;
`endif

    // Occupancy after this cycle's pop plus the word arriving from ROM decides issue.
    assign w_pop = (w_count != 2'd0) && pix_ready;
    assign w_occ = w_count - 2'(w_pop) + 2'(r_in_flight);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_issue     = 1'b0;
        w_last_addr = (r_x == X_W'(SPR_W - 1)) && (r_y == Y_W'(SPR_H - 1));
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                w_issue = (w_occ < 2'd2);
                if (w_issue && w_last_addr) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pop && w_head.last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Next raster position and its (possibly mirrored) ROM column.
    always_comb begin
        w_x_nxt = r_x + X_W'(1);
        w_y_nxt = r_y;
        if (r_x == X_W'(SPR_W - 1)) begin
            w_x_nxt = '0;
            w_y_nxt = r_y + Y_W'(1);
        end
        w_col = w_flip ? ~w_x_nxt : w_x_nxt;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_base      <= '0;
            r_addr      <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_tag_x     <= '0;
            r_tag_y     <= '0;
            r_in_flight <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_in_flight <= w_issue;
            r_busy      <= (w_state_nxt == FETCH) || (w_state_nxt == DRAIN);
            r_done      <= (w_state_nxt == DONE);
            if (w_issue) begin
                r_tag_x <= r_x;
                r_tag_y <= r_y;
            end
            if (w_start_ok) begin
                r_base <= base_addr;
                r_x    <= '0;
                r_y    <= '0;
                r_addr <= base_addr + ADDR_W'({{Y_W{1'b0}}, {X_W{w_flip_start}}});
            end else if (w_issue && !w_last_addr) begin
                r_x    <= w_x_nxt;
                r_y    <= w_y_nxt;
                r_addr <= r_base + ADDR_W'({w_y_nxt, w_col});
            end
        end
    end

    always_comb begin
        w_push_pix             = '0;
        w_push_pix.data        = rom_data;
        w_push_pix.x           = r_tag_x;
        w_push_pix.y           = r_tag_y;
        w_push_pix.transparent = (rom_data == KEY_COLOR);
        w_push_pix.last        = (r_tag_x == X_W'(SPR_W - 1)) && (r_tag_y == Y_W'(SPR_H - 1));
    end

    pixel_skid_fifo u_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_push  (r_in_flight),
        .i_data  (w_push_pix),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign busy            = r_busy;
    assign done            = r_done;
    assign rom_addr        = r_addr;
    assign pix_valid       = (w_count != 2'd0);
    assign pix_data        = w_head.data;
    assign pix_x           = w_head.x;
    assign pix_y           = w_head.y;
    assign pix_transparent = w_head.transparent;
    assign pix_last        = w_head.last;

endmodule

// File: tb/tb_sprite_pixel_fetcher.sv
// Directed bench for sprite_pixel_fetcher with a registered-read ROM model.
module tb_sprite_pixel_fetcher;

    localparam logic [23:0] KEY = 24'hFF00FF;

    logic        clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic [12:0] base_addr = '0;
`ifdef SPRITE_FLIPX_EN
    logic        flip_x = 1'b0;
`endif
    logic        busy, done, pix_valid, pix_transparent, pix_last;
    logic        pix_ready = 1'b0;
    logic [12:0] rom_addr;
    logic [23:0] rom_data, pix_data;
    logic [5:0]  pix_x, pix_y;

    logic [23:0] rom_mem [8192];
    logic [23:0] hs_data [4][4096];
    logic [13:0] hs_tags [4][4096];
    logic [12:0] addr_log [4096];

    int n_chk = 0;
    int n_fail = 0;
    int hs_cnt, done_cnt, done_cyc, first_valid, data_err, addr_err;
    int stab_err, stall_cnt, tr_cnt, busy_at_done;
    logic [15:0] lfsr = 16'hACE1;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    sprite_pixel_fetcher dut (
        .Clk             (clk),
        .Reset_n         (Reset_n),
        .start           (start),
        .base_addr       (base_addr),
`ifdef SPRITE_FLIPX_EN
        .flip_x          (flip_x),
`endif
        .busy            (busy),
        .done            (done),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .pix_data        (pix_data),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .pix_transparent (pix_transparent),
        .pix_last        (pix_last)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Fetch one sprite; mode 0 = ready held high, 1 = LFSR ready. Stops early on abort_at handshakes.
    task automatic run_sprite(input int run, input logic [12:0] base, input int mode,
                              input logic flip, input int repulse_at, input int abort_at);
        logic [23:0] prev_data;
        logic [13:0] prev_tags;
        logic        prev_stall;
        logic [12:0] ea;
        int          ex, ey, col;
        hs_cnt = 0; done_cnt = 0; done_cyc = -1; first_valid = -1; data_err = 0;
        addr_err = 0; stab_err = 0; stall_cnt = 0; tr_cnt = 0; busy_at_done = -1;
        prev_stall = 1'b0; prev_data = '0; prev_tags = '0;
        @(negedge clk);
        start = 1'b1;
        base_addr = base;
`ifdef SPRITE_FLIPX_EN
        flip_x = flip;
`endif
        pix_ready = (mode == 0);
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            start = (i == repulse_at);
            if (i < 4096) begin
                ey = i / 64;
                ex = i % 64;
                col = flip ? 63 - ex : ex;
                ea = 13'(int'(base) + ey * 64 + col);
                addr_log[i] = rom_addr;
                if (mode == 0 && rom_addr !== ea) addr_err++;
            end
            if (prev_stall && (!pix_valid || pix_data !== prev_data ||
                {pix_x, pix_y, pix_transparent, pix_last} !== prev_tags)) stab_err++;
            if (done) begin
                done_cnt++;
                done_cyc = i;
                busy_at_done = int'(busy);
            end
            if (pix_valid && first_valid < 0) first_valid = i;
            if (mode != 0) begin
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                pix_ready = lfsr[0];
            end
            if (pix_valid && pix_ready && hs_cnt < 4096) begin
                ey = hs_cnt / 64;
                ex = hs_cnt % 64;
                col = flip ? 63 - ex : ex;
                ea = 13'(int'(base) + ey * 64 + col);
                if (pix_data !== rom_mem[ea] || pix_x !== 6'(ex) || pix_y !== 6'(ey) ||
                    pix_transparent !== (rom_mem[ea] == KEY) || pix_last !== (hs_cnt == 4095))
                    data_err++;
                if (pix_transparent) tr_cnt++;
                hs_data[run][hs_cnt] = pix_data;
                hs_tags[run][hs_cnt] = {pix_x, pix_y, pix_transparent, pix_last};
                hs_cnt++;
            end else if (pix_valid && pix_ready) begin
                data_err++;
            end
            prev_stall = pix_valid && !pix_ready;
            if (prev_stall) stall_cnt++;
            prev_data = pix_data;
            prev_tags = {pix_x, pix_y, pix_transparent, pix_last};
            if (abort_at > 0 && hs_cnt == abort_at) begin
                Reset_n = 1'b0;
                break;
            end
            if (done_cyc >= 0 && i >= done_cyc + 2) break;
        end
        start = 1'b0;
        pix_ready = 1'b0;
    endtask

    typedef struct {
        int          run;
        int          idx;
        logic [12:0] addr;
        logic [5:0]  x;
        logic [5:0]  y;
        logic        tr;
        logic        last;
    } vec_t;

    vec_t vecs [10];

    initial begin
        for (int a = 0; a < 8192; a++) rom_mem[a] = {11'h3A5, 13'(a)};
        rom_mem[5] = KEY;

        vecs[0] = '{0, 0,    13'h0000, 6'd0,  6'd0,  1'b0, 1'b0};
        vecs[1] = '{0, 5,    13'h0005, 6'd5,  6'd0,  1'b1, 1'b0};
        vecs[2] = '{0, 69,   13'h0045, 6'd5,  6'd1,  1'b0, 1'b0};
        vecs[3] = '{0, 4095, 13'h0FFF, 6'd63, 6'd63, 1'b0, 1'b1};
        vecs[4] = '{1, 63,   13'h1FFF, 6'd63, 6'd0,  1'b0, 1'b0};
        vecs[5] = '{1, 64,   13'h0000, 6'd0,  6'd1,  1'b0, 1'b0};
        vecs[6] = '{1, 69,   13'h0005, 6'd5,  6'd1,  1'b1, 1'b0};
        vecs[7] = '{1, 4095, 13'h0FBF, 6'd63, 6'd63, 1'b0, 1'b1};
        vecs[8] = '{2, 0,    13'h0123, 6'd0,  6'd0,  1'b0, 1'b0};
        vecs[9] = '{2, 100,  13'h0187, 6'd36, 6'd1,  1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_busy_done", {busy, done}, 2'b00);
        chk("reset_rom_addr", rom_addr, 13'h0);
        chk("reset_pix_valid", pix_valid, 1'b0);
        chk("reset_pix_fields", {pix_data, pix_x, pix_y, pix_transparent, pix_last}, '0);
        Reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_sprite(0, 13'h0000, 0, 1'b0, 50, 0);
        chk("r0_handshakes", hs_cnt, 4096);
        chk("r0_done_count", done_cnt, 1);
        chk("r0_done_cycle", done_cyc, 4098);
        chk("r0_busy_at_done", busy_at_done, 0);
        chk("r0_first_valid", first_valid, 2);
        chk("r0_addr_seq", addr_err, 0);
        chk("r0_data", data_err, 0);
        chk("r0_transparent_cnt", tr_cnt, 1);

        run_sprite(1, 13'h1FC0, 0, 1'b0, -1, 0);
        chk("r1_handshakes", hs_cnt, 4096);
        chk("r1_done_count", done_cnt, 1);
        chk("r1_addr_seq", addr_err, 0);
        chk("r1_addr_before_wrap", addr_log[63], 13'h1FFF);
        chk("r1_addr_after_wrap", addr_log[64], 13'h0000);
        chk("r1_data", data_err, 0);

        run_sprite(2, 13'h0123, 1, 1'b0, -1, 0);
        chk("r2_handshakes", hs_cnt, 4096);
        chk("r2_done_count", done_cnt, 1);
        chk("r2_data", data_err, 0);
        chk("r2_stall_stable", stab_err, 0);
        chk("r2_stalls_seen", stall_cnt > 100, 1'b1);

        for (int v = 0; v < 10; v++) begin
            chk($sformatf("vec%0d_data", v), hs_data[vecs[v].run][vecs[v].idx], rom_mem[vecs[v].addr]);
            chk($sformatf("vec%0d_tags", v), hs_tags[vecs[v].run][vecs[v].idx],
                {vecs[v].x, vecs[v].y, vecs[v].tr, vecs[v].last});
        end

`ifdef SPRITE_FLIPX_EN
        run_sprite(3, 13'h0000, 0, 1'b1, -1, 0);
        chk("r3_handshakes", hs_cnt, 4096);
        chk("r3_addr_seq", addr_err, 0);
        chk("r3_first_addr", addr_log[0], 13'd63);
        chk("r3_row0_end_addr", addr_log[63], 13'd0);
        chk("r3_data", data_err, 0);
`endif

        run_sprite(0, 13'h0000, 0, 1'b0, -1, 100);
        chk("abort_reached", hs_cnt, 100);
        @(posedge clk);
        #1;
        chk("abort_outputs_zero", {busy, done, rom_addr, pix_valid, pix_data, pix_x, pix_y,
                                   pix_transparent, pix_last}, '0);
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        Reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
